// File: rtl/seq_pkg.sv
// Shared types and helpers for the multicycle sequencer.
// Macro SEQ_PERF_CNT_EN (see multicycle_sequencer) adds perf counters.
package seq_pkg;

    localparam int SEQ_DATA_W = 16;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_t;

    // Ceiling log2; used for pointer and phase index widths.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_instr_fifo.sv
// Instruction queue: storage, wrapping pointers, occupancy, full/empty.
// Ports: clk, rst (async, active-low), clear (sync), push/wdata, pop/rdata, full, empty.
module seq_instr_fifo
    import seq_pkg::*;
#(
    parameter int DATA_W = SEQ_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers rely on DEPTH being a power of two to wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_W+1)'(do_push)
                           - (PTR_W+1)'(do_pop);
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Phase sequencer and instruction front end for the multicycle core.
// Ports: clk, rst (async, active-low); instr_valid/instr_ready/instr_data
//   in; stall, flush; ir, ir_load, pc_en, phase_oh, phase_idx, busy out.
// SEQ_PERF_CNT_EN adds cyc_cnt and retired_cnt outputs.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int DATA_W     = SEQ_DATA_W,
    parameter int NUM_PHASES = 5,
    parameter int IQ_DEPTH   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           instr_valid,
    output logic                           instr_ready,
    input  logic [DATA_W-1:0]              instr_data,
    input  logic                           stall,
    input  logic                           flush,
    output logic [DATA_W-1:0]              ir,
    output logic                           ir_load,
    output logic                           pc_en,
    output logic [NUM_PHASES-1:0]          phase_oh,
    output logic [clog2(NUM_PHASES)-1:0]   phase_idx,
    output logic                           busy
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                    cyc_cnt,
    output logic [31:0]                    retired_cnt
`endif
);

    localparam int IDX_W = clog2(NUM_PHASES);

    seq_state_t              state;
    seq_state_t              state_n;
    logic [IDX_W-1:0]        idx_n;
    logic [NUM_PHASES-1:0]   oh_n;
    logic [DATA_W-1:0]       ir_n;
    logic                    load_n;
    logic                    pop;
    logic                    push;
    logic                    retire;
    logic                    last;
    logic                    armed;
    logic                    full;
    logic                    empty;
    logic [DATA_W-1:0]       head;

    // armed keeps instr_ready low while reset is asserted.
    assign instr_ready = armed && !full;
    assign push        = instr_valid && instr_ready && !flush;
    assign busy        = (state == SEQ_RUN);
    assign last        = (phase_idx == IDX_W'(NUM_PHASES - 1));

    seq_instr_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (IQ_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (push),
        .wdata (instr_data),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_n = state;
        idx_n   = phase_idx;
        ir_n    = ir;
        load_n  = 1'b0;
        pop     = 1'b0;
        retire  = 1'b0;
        if (flush) begin
            state_n = SEQ_IDLE;
            idx_n   = '0;
        end else begin
            unique case (state)
                SEQ_IDLE: begin
                    pop = !empty;
                end
                SEQ_RUN: begin
                    if (!stall) begin
                        if (last) begin
                            retire = 1'b1;
                            if (!empty) begin
                                pop = 1'b1;
                            end else begin
                                state_n = SEQ_IDLE;
                                idx_n   = '0;
                            end
                        end else begin
                            idx_n = phase_idx + 1'b1;
                        end
                    end
                end
            endcase
        end
        // A pop always starts phase 0 of a fresh instruction.
        if (pop) begin
            ir_n    = head;
            load_n  = 1'b1;
            idx_n   = '0;
            state_n = SEQ_RUN;
        end
        oh_n = (state_n == SEQ_RUN) ? (NUM_PHASES'(1) << idx_n) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SEQ_IDLE;
            phase_idx <= '0;
            phase_oh  <= '0;
            ir        <= '0;
            ir_load   <= 1'b0;
            pc_en     <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state     <= state_n;
            phase_idx <= idx_n;
            phase_oh  <= oh_n;
            ir        <= ir_n;
            ir_load   <= load_n;
            pc_en     <= load_n;
            armed     <= 1'b1;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt     <= '0;
            retired_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'(busy);
            if (retire) retired_cnt <= retired_cnt + 32'd1;
        end
    end
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed plus random bench for multicycle_sequencer with a queue-based
// reference model; builds with or without SEQ_PERF_CNT_EN.
module tb_multicycle_sequencer;

    localparam int DW = 16;
    localparam int NP = 5;
    localparam int QD = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [DW-1:0] instr_data = '0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] ir;
    logic          ir_load;
    logic          pc_en;
    logic [NP-1:0] phase_oh;
    logic [2:0]    phase_idx;
    logic          busy;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]   cyc_cnt;
    logic [31:0]   retired_cnt;
`endif

    multicycle_sequencer #(
        .DATA_W     (DW),
        .NUM_PHASES (NP),
        .IQ_DEPTH   (QD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .stall       (stall),
        .flush       (flush),
        .ir          (ir),
        .ir_load     (ir_load),
        .pc_en       (pc_en),
        .phase_oh    (phase_oh),
        .phase_idx   (phase_idx),
        .busy        (busy)
`ifdef SEQ_PERF_CNT_EN
        ,
        .cyc_cnt     (cyc_cnt),
        .retired_cnt (retired_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    // Reference model: m_ph = -1 when idle, else current phase number.
    int            m_ph;
    logic [DW-1:0] m_ir;
    bit            m_load;
    bit            m_armed;
    logic [DW-1:0] m_q[$];
    int unsigned   m_cyc;
    int unsigned   m_ret;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] e_oh;
        e_oh = (m_ph < 0) ? 32'd0 : (32'd1 << m_ph);
        chk("busy", 32'(busy), 32'(m_ph >= 0));
        chk("phase_idx", 32'(phase_idx), (m_ph < 0) ? 32'd0 : 32'(m_ph));
        chk("phase_oh", 32'(phase_oh), e_oh);
        chk("ir", 32'(ir), 32'(m_ir));
        chk("ir_load", 32'(ir_load), 32'(m_load));
        chk("pc_en", 32'(pc_en), 32'(m_load));
        chk("instr_ready", 32'(instr_ready),
            32'(m_armed && (m_q.size() < QD)));
`ifdef SEQ_PERF_CNT_EN
        chk("cyc_cnt", cyc_cnt, m_cyc);
        chk("retired_cnt", retired_cnt, m_ret);
`endif
    endtask

    task automatic model_reset();
        m_ph = -1;
        m_ir = '0;
        m_load = 1'b0;
        m_armed = 1'b0;
        m_q.delete();
        m_cyc = 0;
        m_ret = 0;
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d,
                        input bit s, input bit f);
        bit acc;
        instr_valid = v;
        instr_data  = d;
        stall       = s;
        flush       = f;
        acc = v && m_armed && (m_q.size() < QD);
        if (m_ph >= 0) m_cyc++;
        m_load = 1'b0;
        if (f) begin
            m_q.delete();
            m_ph = -1;
        end else begin
            if (m_ph < 0) begin
                if (m_q.size() > 0) begin
                    m_ir = m_q.pop_front();
                    m_load = 1'b1;
                    m_ph = 0;
                end
            end else if (!s) begin
                if (m_ph < NP - 1) begin
                    m_ph++;
                end else begin
                    m_ret++;
                    if (m_q.size() > 0) begin
                        m_ir = m_q.pop_front();
                        m_load = 1'b1;
                        m_ph = 0;
                    end else begin
                        m_ph = -1;
                    end
                end
            end
            // The word pushed this cycle is only visible from next cycle.
            if (acc) m_q.push_back(d);
        end
        m_armed = 1'b1;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0);
    endtask

    // Asserts reset between edges and checks outputs before any clock edge.
    task automatic do_reset();
        instr_valid = 0;
        stall = 0;
        flush = 0;
        rst = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_phase_oh", 32'(phase_oh), 32'd0);
        chk("rst_phase_idx", 32'(phase_idx), 32'd0);
        chk("rst_ir", 32'(ir), 32'd0);
        chk("rst_ir_load", 32'(ir_load), 32'd0);
        chk("rst_pc_en", 32'(pc_en), 32'd0);
        chk("rst_ready", 32'(instr_ready), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int cnt_a;
        int cnt_b;
        bit took;

        #1;
        do_reset();

        // Idle after reset: ready stays high, nothing runs.
        idle(6);

        // Single instruction, no stall.
        step(1, 16'h1234, 0, 0);
        idle(1);
        chk("t2_ir_load", 32'(ir_load), 32'd1);
        chk("t2_ir", 32'(ir), 32'h1234);
        idle(6);

        // Back-to-back instructions: 10 busy cycles, no gap.
        cnt_a = 0;
        step(1, 16'hA001, 0, 0); cnt_a += int'(busy);
        step(1, 16'hA002, 0, 0); cnt_a += int'(busy);
        for (int i = 0; i < 12; i++) begin
            step(0, '0, 0, 0);
            cnt_a += int'(busy);
        end
        chk("t3_busy_cycles", 32'(cnt_a), 32'd10);

        // Stall three cycles in phase 2.
        cnt_a = 0;
        cnt_b = 0;
        step(1, 16'hB000, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 0, 0);
            cnt_a += int'(busy && phase_idx == 3'd2);
            cnt_b += int'(busy);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 1, 0);
            cnt_a += int'(busy && phase_idx == 3'd2);
            cnt_b += int'(busy);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, '0, 0, 0);
            cnt_a += int'(busy && phase_idx == 3'd2);
            cnt_b += int'(busy);
        end
        chk("t4_phase2_cycles", 32'(cnt_a), 32'd4);
        chk("t4_busy_cycles", 32'(cnt_b), 32'd8);

        // Fill the queue while running; a third word waits for a pop.
        step(1, 16'hC000, 0, 0);
        step(1, 16'hC001, 0, 0);
        step(1, 16'hC002, 0, 0);
        chk("t5_ready_full", 32'(instr_ready), 32'd0);
        took = 1'b0;
        for (int i = 0; i < 20 && !took; i++) begin
            took = instr_ready;
            step(1, 16'hC003, 0, 0);
        end
        chk("t5_third_taken", 32'(took), 32'd1);
        idle(20);

        // Flush in phase 3 with one queued word and a same-cycle push.
        step(1, 16'hD000, 0, 0);
        step(0, '0, 0, 0);
        step(1, 16'hD001, 0, 0);
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        chk("t6_phase3", 32'(phase_idx), 32'd3);
        step(1, 16'hD002, 0, 1);
        chk("t6_ir_kept", 32'(ir), 32'hD000);
        chk("t6_idle", 32'(busy), 32'd0);
        idle(3);

        // Reset in the middle of an instruction.
        step(1, 16'hE000, 0, 0);
        idle(2);
        do_reset();
        idle(3);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), DW'($urandom),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 31) == 0));
        end
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
